// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and defaults for the instruction memory responder
package imem_pkg;

  localparam int IMEM_LATENCY    = 3;
  localparam int IMEM_DEPTH_LOG2 = 10;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_HALTED
  } state_t;

  // Exactly one of read/write, on a word-aligned byte address.
  function automatic logic req_legal(input logic rd, input logic wr, input logic a0);
    return (rd ^ wr) && !a0;
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word storage: synchronous write, registered read, contents never reset
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  word_t                 wdata,
  output word_t                 rdata
);

  word_t mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/imem_resp.sv
// rtl/imem_resp.sv - fixed-latency request/response FSM in front of imem_array
module imem_resp
  import imem_pkg::*;
#(
  parameter int LATENCY    = IMEM_LATENCY,
  parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] DataIn,
  input  logic        Halt,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Err
);

  localparam logic [2:0] LOAD = 3'(LATENCY - 1);

  state_t                state;
  logic [2:0]            cnt;
  logic                  halted;
  logic                  op_wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  word_t                 data_q;
  logic                  have_rd;
  word_t                 rdata;

  logic                  open_st;
  logic                  accept;
  logic                  reject;
  logic                  finish_busy;
  logic                  finish_direct;
  logic                  access;
  logic                  acc_wr;
  logic [DEPTH_LOG2-1:0] acc_idx;
  word_t                 acc_data;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same word.
  assign unused_addr_hi = ^Addr[15:DEPTH_LOG2+1];

  assign open_st = (state == ST_IDLE) || (state == ST_DONE);
  assign accept  = open_st && !halted && !Halt && req_legal(Rd, Wr, Addr[0]);
  assign reject  = open_st && !halted && !Halt && (Rd || Wr) && !req_legal(Rd, Wr, Addr[0]);

  assign finish_busy   = (state == ST_BUSY) && (cnt == 3'd1);
  assign finish_direct = accept && (LOAD == 3'd0);
  assign access        = finish_busy || finish_direct;

  // With LATENCY=1 the access happens on the accepting edge, before the latches exist.
  assign acc_wr   = finish_direct ? Wr                   : op_wr_q;
  assign acc_idx  = finish_direct ? Addr[DEPTH_LOG2:1]   : idx_q;
  assign acc_data = finish_direct ? DataIn               : data_q;

  imem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (access && acc_wr),
    .re    (access && !acc_wr),
    .addr  (acc_idx),
    .wdata (acc_data),
    .rdata (rdata)
  );

  assign DataOut = have_rd ? rdata : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      halted  <= 1'b0;
      Done    <= 1'b0;
      Stall   <= 1'b0;
      Err     <= 1'b0;
      have_rd <= 1'b0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      Done  <= 1'b0;
      Stall <= 1'b0;
      Err   <= 1'b0;
      if (Halt) halted <= 1'b1;
      if (access && !acc_wr) have_rd <= 1'b1;

      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (halted || Halt) begin
            state <= ST_HALTED;
          end else if (accept) begin
            op_wr_q <= Wr;
            idx_q   <= Addr[DEPTH_LOG2:1];
            data_q  <= DataIn;
            cnt     <= LOAD;
            if (LOAD == 3'd0) begin
              state <= ST_DONE;
              Done  <= 1'b1;
            end else begin
              state <= ST_BUSY;
              Stall <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
            Err   <= reject;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= ST_DONE;
            Done  <= 1'b1;
          end else begin
            Stall <= 1'b1;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_resp.sv
// tb/tb_imem_resp.sv - directed and random checks of imem_resp against a word-array model
module tb_imem_resp;

  localparam int L  = 3;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Halt, Done, Stall, Err;

  imem_resp #(.LATENCY(L), .DEPTH_LOG2(DL)) dut (
    .clk     (clk),
    .rst     (rst),
    .Addr    (Addr),
    .Rd      (Rd),
    .Wr      (Wr),
    .DataIn  (DataIn),
    .Halt    (Halt),
    .DataOut (DataOut),
    .Done    (Done),
    .Stall   (Stall),
    .Err     (Err)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  logic [15:0] model_mem [int];
  int          keys [$];
  logic [15:0] last_rd = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % (1 << DL);
  endfunction

  task automatic idle_inputs();
    Rd = 1'b0; Wr = 1'b0; Halt = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
  endtask

  // One accepted access; edge k after acceptance (k=1 is the accepting edge).
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, input bit halt_mid);
    Rd = rd; Wr = wr; Addr = a; DataIn = d; Halt = 1'b0;
    for (int k = 1; k <= L; k++) begin
      tick();
      chk("stall", {15'd0, Stall}, {15'd0, k < L});
      chk("done",  {15'd0, Done},  {15'd0, k == L});
      chk("err_busy", {15'd0, Err}, 16'h0000);
      if (k < L) begin
        Rd = 1'($urandom); Wr = 1'($urandom);
        Addr = 16'($urandom); DataIn = 16'($urandom);
        Halt = halt_mid && (k == 1);
      end
    end
    if (wr) begin
      if (!model_mem.exists(widx(a))) keys.push_back(widx(a));
      model_mem[widx(a)] = d;
    end else begin
      last_rd = model_mem[widx(a)];
    end
    chk("dataout", DataOut, last_rd);
    idle_inputs();
  endtask

  task automatic bad_req(input logic rd, input logic wr, input logic [15:0] a);
    Rd = rd; Wr = wr; Addr = a; DataIn = 16'($urandom);
    tick();
    chk("err_pulse", {15'd0, Err},   16'h0001);
    chk("err_done",  {15'd0, Done},  16'h0000);
    chk("err_stall", {15'd0, Stall}, 16'h0000);
    idle_inputs();
    tick();
    chk("err_clear", {15'd0, Err},  16'h0000);
    chk("err_nodone", {15'd0, Done}, 16'h0000);
    chk("err_hold", DataOut, last_rd);
  endtask

  initial begin
    logic [15:0] a, d, w0, w2;
    int          r, j;

    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_dataout", DataOut, 16'h0000);
    chk("rst_done",  {15'd0, Done},  16'h0000);
    chk("rst_stall", {15'd0, Stall}, 16'h0000);
    chk("rst_err",   {15'd0, Err},   16'h0000);

    do_access(1'b0, 1'b1, 16'h0004, 16'hBEEF, 1'b0);
    tick();
    chk("idle_done", {15'd0, Done}, 16'h0000);
    do_access(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    chk("beef", DataOut, 16'hBEEF);

    bad_req(1'b1, 1'b0, 16'h0003);
    bad_req(1'b1, 1'b1, 16'h0004);
    bad_req(1'b0, 1'b1, 16'h0005);

    w0 = 16'($urandom);
    w2 = 16'($urandom);
    do_access(1'b0, 1'b1, 16'h0000, w0, 1'b0);
    do_access(1'b0, 1'b1, 16'h0002, w2, 1'b0);
    do_access(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("b2b_w0", DataOut, w0);
    do_access(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
    chk("b2b_w2", DataOut, w2);
    tick();

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4 || keys.size() == 0) begin
        a = 16'($urandom) & 16'hFFFE;
        do_access(1'b0, 1'b1, a, 16'($urandom), 1'b0);
      end else if (r < 8) begin
        j = $urandom_range(0, keys.size() - 1);
        a = 16'(keys[j] * 2 + 2048 * $urandom_range(0, 31));
        do_access(1'b1, 1'b0, a, 16'h0000, 1'b0);
      end else if (r == 8) begin
        bad_req(1'b1, 1'b0, 16'($urandom) | 16'h0001);
      end else begin
        bad_req(1'b1, 1'b1, 16'($urandom) & 16'hFFFE);
      end
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();

    do_access(1'b0, 1'b1, 16'h0010, 16'hA5A5, 1'b0);
    tick();
    Rd = 1'b0; Wr = 1'b1; Addr = 16'h0010; DataIn = 16'h1234;
    tick();
    chk("abort_stall", {15'd0, Stall}, 16'h0001);
    idle_inputs();
    #2 rst = 1'b1;
    last_rd = 16'h0000;
    #1;
    chk("async_stall",   {15'd0, Stall}, 16'h0000);
    chk("async_done",    {15'd0, Done},  16'h0000);
    chk("async_dataout", DataOut, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    chk("abort_nowrite", DataOut, 16'hA5A5);
    tick();

    d = 16'($urandom);
    do_access(1'b0, 1'b1, 16'h0806, d, 1'b0);
    tick();
    do_access(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0);
    chk("wrap", DataOut, d);
    tick();

    do_access(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1);
    chk("halt_data", DataOut, 16'hBEEF);
    for (int i = 0; i < 6; i++) begin
      Rd = (i % 2 == 0); Wr = (i % 2 == 1); Addr = (i == 3) ? 16'h0003 : 16'h0000;
      tick();
      chk("halt_done",  {15'd0, Done},  16'h0000);
      chk("halt_stall", {15'd0, Stall}, 16'h0000);
      chk("halt_err",   {15'd0, Err},   16'h0000);
      chk("halt_hold",  DataOut, 16'hBEEF);
    end
    idle_inputs();
    rst = 1'b1;
    last_rd = 16'h0000;
    tick();
    rst = 1'b0;
    tick();
    chk("halt_rst_dataout", DataOut, 16'h0000);
    do_access(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    chk("after_halt", DataOut, 16'hBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
